// File: rtl/gambit_memq_pkg.sv
// Shared types for the gambit_memq request queue.
// Address, data and tag widths are set here; the queue entry and the
// top-level port widths follow them.
package gambit_memq_pkg;

    localparam int AMSB = 31;   // address MSB (matches agen ma output)
    localparam int DBW  = 52;   // data bus width
    localparam int IDW  = 4;    // request tag width

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } memq_state_t;

    typedef struct packed {
        logic            store;
        logic [AMSB:0]   adr;
        logic [DBW-1:0]  dat;
        logic [IDW-1:0]  id;
    } memq_entry_t;

endpackage

// File: rtl/gambit_memq_fifo.sv
// In-order entry storage for gambit_memq.
// The head is read combinationally so the sequencer can launch a bus
// cycle on the edge after a push into an empty queue. A flush drops
// everything except the head when that head is on the bus.
module gambit_memq_fifo
    import gambit_memq_pkg::*;
#(
    parameter int QDEP = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  memq_entry_t wdata_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic        keep_head_i,
    output memq_entry_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int PW = (QDEP > 1) ? $clog2(QDEP) : 1;
    localparam int CW = PW + 1;

    memq_entry_t    r_mem [QDEP];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    assign head_o  = r_mem[r_rptr];
    assign full_o  = (r_count == CW'(QDEP));
    assign empty_o = (r_count == '0);

    // Entry storage write; no reset needed on the data itself
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo QDEP (power of two)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            if (keep_head_i && !pop_i) begin
                // in-flight head survives; it completes later and is popped then
                r_wptr  <= r_rptr + PW'(1);
                r_count <= CW'(1);
            end else if (keep_head_i && pop_i) begin
                // head completes on the same edge as the flush: queue empties
                r_rptr  <= r_rptr + PW'(1);
                r_wptr  <= r_rptr + PW'(1);
                r_count <= '0;
            end else begin
                r_wptr  <= r_rptr;
                r_count <= '0;
            end
        end else begin
            if (push_i) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (pop_i) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (push_i && !pop_i) begin
                r_count <= r_count + CW'(1);
            end else if (pop_i && !push_i) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/gambit_memq.sv
// Memory request queue and single-outstanding bus sequencer.
// Buffers requests from the address generator, runs one Wishbone-style
// cycle per request in order, and reports tagged completions.
// Optional build macro: GAMBIT_MEMQ_TIMEOUT_EN adds a bus timeout of
// TOCNT cycles that terminates a stuck cycle as an error.
module gambit_memq
    import gambit_memq_pkg::*;
#(
    parameter int QDEP  = 4,
    parameter int TOCNT = 255
) (
    input  logic            rst_i,
    input  logic            clk_i,
    input  logic            req_i,
    output logic            req_rdy_o,
    input  logic            req_store_i,
    input  logic [AMSB:0]   req_adr_i,
    input  logic [DBW-1:0]  req_dat_i,
    input  logic [IDW-1:0]  req_id_i,
    input  logic            flush_i,
    output logic            done_o,
    output logic [IDW-1:0]  done_id_o,
    output logic [DBW-1:0]  done_dat_o,
    output logic            done_err_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [AMSB:0]   adr_o,
    output logic [DBW-1:0]  dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [DBW-1:0]  dat_i
);

    memq_state_t r_state;
    logic        r_flushed;     // in-flight cycle belongs to a flushed stream

    memq_entry_t w_entry;
    memq_entry_t w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_timeout;
    logic        w_term;
    logic        w_err;

    assign req_rdy_o = !w_full && !flush_i;
    assign w_push    = req_i && req_rdy_o;

    assign w_entry.store = req_store_i;
    assign w_entry.adr   = req_adr_i;
    assign w_entry.dat   = req_store_i ? req_dat_i : '0;
    assign w_entry.id    = req_id_i;

`ifdef GAMBIT_MEMQ_TIMEOUT_EN
    localparam int TW = ($clog2(TOCNT + 1) > 8) ? $clog2(TOCNT + 1) : 8;
    logic [TW-1:0] r_tocnt;

    // Cycles spent in BUS; cleared while idle so it starts at zero on entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tocnt <= '0;
        end else if (r_state == IDLE) begin
            r_tocnt <= '0;
        end else begin
            r_tocnt <= r_tocnt + TW'(1);
        end
    end

    // Fires on the TOCNT-th edge spent in BUS
    assign w_timeout = (r_state == BUS) && (r_tocnt == TW'(TOCNT - 1));
`else
    // Feature compiled out; TOCNT stays in the parameter list so both builds share one interface
    assign w_timeout = 1'b0 && (TOCNT > 0);
`endif

    // A real ack beats a timeout landing on the same edge; err_i beats ack_i
    assign w_term = ack_i || err_i || w_timeout;
    assign w_err  = err_i || (w_timeout && !ack_i);
    assign w_pop  = (r_state == BUS) && w_term;

    gambit_memq_fifo #(
        .QDEP (QDEP)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .wdata_i     (w_entry),
        .pop_i       (w_pop),
        .flush_i     (flush_i),
        .keep_head_i (r_state == BUS),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Sequencer: launches one bus cycle per head entry and registers the completion
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_flushed  <= 1'b0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            adr_o      <= '0;
            dat_o      <= '0;
            done_o     <= 1'b0;
            done_id_o  <= '0;
            done_dat_o <= '0;
            done_err_o <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            done_id_o  <= '0;
            done_dat_o <= '0;
            done_err_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty && !flush_i) begin
                        cyc_o     <= 1'b1;
                        stb_o     <= 1'b1;
                        we_o      <= w_head.store;
                        adr_o     <= w_head.adr;
                        dat_o     <= w_head.store ? w_head.dat : '0;
                        r_flushed <= 1'b0;
                        r_state   <= BUS;
                    end
                end
                BUS: begin
                    if (w_term) begin
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        we_o      <= 1'b0;
                        adr_o     <= '0;
                        dat_o     <= '0;
                        r_flushed <= 1'b0;
                        r_state   <= IDLE;
                        if (!(r_flushed || flush_i)) begin
                            done_o     <= 1'b1;
                            done_id_o  <= w_head.id;
                            done_err_o <= w_err;
                            done_dat_o <= (!w_head.store && !w_err) ? dat_i : '0;
                        end
                    end else if (flush_i) begin
                        r_flushed <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gambit_memq.sv
// Self-checking bench for gambit_memq: expected completions are queued
// when the bus response is driven and compared when done_o fires.
module tb_gambit_memq;

    logic            rst_i, clk_i;
    logic            req_i, req_rdy_o, req_store_i;
    logic [31:0]     req_adr_i;
    logic [51:0]     req_dat_i;
    logic [3:0]      req_id_i;
    logic            flush_i;
    logic            done_o;
    logic [3:0]      done_id_o;
    logic [51:0]     done_dat_o;
    logic            done_err_o;
    logic            cyc_o, stb_o, we_o;
    logic [31:0]     adr_o;
    logic [51:0]     dat_o;
    logic            ack_i, err_i;
    logic [51:0]     dat_i;

    typedef struct {
        logic [3:0]  id;
        logic [51:0] dat;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    gambit_memq #(
        .QDEP  (4),
        .TOCNT (8)
    ) dut (
        .rst_i       (rst_i),
        .clk_i       (clk_i),
        .req_i       (req_i),
        .req_rdy_o   (req_rdy_o),
        .req_store_i (req_store_i),
        .req_adr_i   (req_adr_i),
        .req_dat_i   (req_dat_i),
        .req_id_i    (req_id_i),
        .flush_i     (flush_i),
        .done_o      (done_o),
        .done_id_o   (done_id_o),
        .done_dat_o  (done_dat_o),
        .done_err_o  (done_err_o),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .ack_i       (ack_i),
        .err_i       (err_i),
        .dat_i       (dat_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every completion must match the oldest expectation
    always @(negedge clk_i) begin
        if (!rst_i && done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {60'd0, done_id_o}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] done id=%0d dat=0x%0h err=%0d", done_id_o, done_dat_o, done_err_o);
                chk("done_id",  {60'd0, done_id_o},  {60'd0, e.id});
                chk("done_dat", {12'd0, done_dat_o}, {12'd0, e.dat});
                chk("done_err", {63'd0, done_err_o}, {63'd0, e.err});
            end
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic st, input logic [31:0] adr, input logic [51:0] d, input logic [3:0] id);
        req_i = 1'b1; req_store_i = st; req_adr_i = adr; req_dat_i = d; req_id_i = id;
        tick();
        req_i = 1'b0; req_store_i = 1'b0; req_adr_i = '0; req_dat_i = '0; req_id_i = '0;
    endtask

    // Bounded wait for a bus cycle to be active
    task automatic wait_cyc(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (cyc_o) break;
            tick();
        end
        if (!cyc_o) chk(tag, 64'd0, 64'd1);
    endtask

    // One-cycle bus response; queues the completion the design must report
    task automatic respond(input logic [51:0] rdat, input logic er, input logic [3:0] id, input logic st);
        exp_t e;
        e.id  = id;
        e.err = er;
        e.dat = (!st && !er) ? rdat : 52'd0;
        sb.push_back(e);
        ack_i = !er; err_i = er; dat_i = rdat;
        tick();
        ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        chk("cyc_drop", {63'd0, cyc_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_i = 1'b1; req_i = 0; req_store_i = 0; req_adr_i = '0; req_dat_i = '0; req_id_i = '0;
        flush_i = 0; ack_i = 0; err_i = 0; dat_i = '0;
        tick(); tick();
        chk("rst_rdy",  {63'd0, req_rdy_o}, 64'd1);
        chk("rst_cyc",  {63'd0, cyc_o},     64'd0);
        chk("rst_done", {63'd0, done_o},    64'd0);
        rst_i = 1'b0;
        tick();

        // Single load, ack two cycles after the bus cycle starts
        push(1'b0, 32'h1000, 52'd0, 4'd3);
        chk("t1_cyc_before", {63'd0, cyc_o}, 64'd0);
        tick();
        chk("t1_cyc_rise", {63'd0, cyc_o}, 64'd1);
        chk("t1_stb",      {63'd0, stb_o}, 64'd1);
        chk("t1_we",       {63'd0, we_o},  64'd0);
        chk("t1_adr",      {32'd0, adr_o}, 64'h1000);
        tick(); tick();
        respond(52'h5A, 1'b0, 4'd3, 1'b0);
        chk("t1_done_pulse", {63'd0, done_o}, 64'd1);
        tick();
        chk("t1_done_once", {63'd0, done_o}, 64'd0);

        // Fill the queue with acks held off, then drain in order
        for (int i = 0; i < 4; i++) push(1'b0, 32'h3000 + 32'(4 * i), 52'd0, 4'(i));
        chk("t2_full_rdy", {63'd0, req_rdy_o}, 64'd0);
        push(1'b0, 32'h3F00, 52'd0, 4'd9);
        for (int i = 0; i < 4; i++) begin
            wait_cyc("t2_wait_cyc");
            chk("t2_adr", {32'd0, adr_o}, {32'd0, 32'h3000 + 32'(4 * i)});
            respond(52'h100 + 52'(i), 1'b0, 4'(i), 1'b0);
            if (i < 3) begin
                tick();
                chk("t2_idle_gap", {63'd0, cyc_o}, 64'd1);
            end
        end
        tick(); tick();
        chk("t2_drained", {63'd0, cyc_o}, 64'd0);

        // Store with bus error, then load with bus error (data masked)
        push(1'b1, 32'h2004, 52'h123, 4'd5);
        wait_cyc("t3_wait_cyc");
        chk("t3_we",  {63'd0, we_o},  64'd1);
        chk("t3_adr", {32'd0, adr_o}, 64'h2004);
        chk("t3_dat", {12'd0, dat_o}, 64'h123);
        respond(52'hFFFF, 1'b1, 4'd5, 1'b1);
        tick();
        push(1'b0, 32'h2008, 52'h999, 4'd6);
        wait_cyc("t3b_wait_cyc");
        chk("t3b_dat_load", {12'd0, dat_o}, 64'd0);
        respond(52'hABC, 1'b1, 4'd6, 1'b0);
        tick();

        // Flush during the first of three queued bus cycles
        push(1'b0, 32'h5000, 52'd0, 4'd7);
        push(1'b0, 32'h5004, 52'd0, 4'd8);
        push(1'b0, 32'h5008, 52'd0, 4'd9);
        wait_cyc("t4_wait_cyc");
        flush_i = 1'b1;
        #1;
        chk("t4_rdy_flush", {63'd0, req_rdy_o}, 64'd0);
        tick();
        flush_i = 1'b0;
        chk("t4_cyc_held", {63'd0, cyc_o}, 64'd1);
        tick();
        ack_i = 1'b1; dat_i = 52'h55;
        tick();
        ack_i = 1'b0; dat_i = '0;
        chk("t4_no_done", {63'd0, done_o}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_cyc_quiet", {63'd0, cyc_o}, 64'd0);
            tick();
        end
        chk("t4_rdy_after", {63'd0, req_rdy_o}, 64'd1);
        push(1'b0, 32'h4000, 52'd0, 4'd10);
        wait_cyc("t4b_wait_cyc");
        chk("t4b_adr", {32'd0, adr_o}, 64'h4000);
        respond(52'h77, 1'b0, 4'd10, 1'b0);
        tick();

        // Asynchronous reset in the middle of a bus cycle
        push(1'b0, 32'h6000, 52'd0, 4'd11);
        wait_cyc("t5_wait_cyc");
        #2 rst_i = 1'b1;
        #1;
        chk("t5_cyc_async", {63'd0, cyc_o},     64'd0);
        chk("t5_stb_async", {63'd0, stb_o},     64'd0);
        chk("t5_rdy_async", {63'd0, req_rdy_o}, 64'd1);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_cyc_quiet", {63'd0, cyc_o}, 64'd0);
        end

`ifdef GAMBIT_MEMQ_TIMEOUT_EN
        // No response: timeout error exactly TOCNT cycles after cyc_o rises
        begin
            exp_t e;
            push(1'b0, 32'h7000, 52'd0, 4'd12);
            wait_cyc("t6_wait_cyc");
            e.id = 4'd12; e.dat = 52'd0; e.err = 1'b1;
            sb.push_back(e);
            k = 0;
            for (int i = 1; i <= 20; i++) begin
                tick();
                if (done_o) begin
                    k = i;
                    break;
                end
            end
            chk("t6_to_lat", 64'(k), 64'd8);
            tick();
        end
`endif

        tick(); tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
